// File: rtl/trap_ctrl_pkg.sv
// Shared constants, FSM encoding and CSR update helpers for the machine-mode trap sequencer.
// Latency: none (declarations only); Backpressure: n/a.
package trap_ctrl_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 32;
  localparam int CSR_ADDR_WIDTH = 12;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  localparam logic [DATA_WIDTH-1:0] CAUSE_IRQ_EXT = 32'h8000_000B;
  localparam logic [DATA_WIDTH-1:0] CAUSE_IRQ_SW  = 32'h8000_0003;
  localparam logic [DATA_WIDTH-1:0] CAUSE_IRQ_TMR = 32'h8000_0007;
  localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [DATA_WIDTH-1:0] CAUSE_EBREAK  = 32'h0000_0003;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_MEPC      = 3'd1,
    ST_WR_MCAUSE    = 3'd2,
    ST_WR_MSTATUS   = 3'd3,
    ST_REDIRECT     = 3'd4,
    ST_MRET_MSTATUS = 3'd5
  } state_e;

  typedef struct packed {
    logic                  take;
    logic                  is_irq;
    logic                  is_mret;
    logic [DATA_WIDTH-1:0] cause;
  } prio_t;

  function automatic logic [DATA_WIDTH-1:0] trap_mstatus(input logic [DATA_WIDTH-1:0] ms);
    logic [DATA_WIDTH-1:0] r;
    r                               = ms;
    r[MSTATUS_MPIE]                 = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]                  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mret_mstatus(input logic [DATA_WIDTH-1:0] ms);
    logic [DATA_WIDTH-1:0] r;
    r                               = ms;
    r[MSTATUS_MIE]                  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE]                 = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Vectored mode only applies to interrupts; exceptions always land on the base.
  function automatic logic [ADDR_WIDTH-1:0] trap_target(input logic [ADDR_WIDTH-1:0] mtvec,
                                                        input logic [DATA_WIDTH-1:0] cause,
                                                        input logic                  is_irq);
    logic [ADDR_WIDTH-1:0] base;
    base = {mtvec[ADDR_WIDTH-1:2], 2'b00};
    if (is_irq && (mtvec[1:0] == 2'b01)) begin
      return base + {25'd0, cause[4:0], 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// EX-stage event inputs, CSR snapshot inputs and CSR-port/redirect outputs of the trap sequencer.
// Latency/backpressure: defined by trap_ctrl; this bundle carries no flow control of its own.
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic                      ex_valid_i;
  logic [ADDR_WIDTH-1:0]     ex_pc_i;
  logic                      ecall_i;
  logic                      ebreak_i;
  logic                      mret_i;
  logic                      irq_ext_i;
  logic                      irq_sw_i;
  logic                      irq_tmr_i;
  logic [DATA_WIDTH-1:0]     mstatus_i;
  logic [DATA_WIDTH-1:0]     mie_i;
  logic [DATA_WIDTH-1:0]     mtvec_i;
  logic [DATA_WIDTH-1:0]     mepc_i;
  logic                      csr_we_o;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o;
  logic [DATA_WIDTH-1:0]     csr_wdata_o;
  logic                      busy_o;
  logic                      stall_o;
  logic                      flush_o;
  logic                      jump_o;
  logic [ADDR_WIDTH-1:0]     jump_addr_o;

  modport master (
    output ex_valid_i, ex_pc_i, ecall_i, ebreak_i, mret_i,
    output irq_ext_i, irq_sw_i, irq_tmr_i,
    output mstatus_i, mie_i, mtvec_i, mepc_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o,
    input  busy_o, stall_o, flush_o, jump_o, jump_addr_o
  );

  modport slave (
    input  ex_valid_i, ex_pc_i, ecall_i, ebreak_i, mret_i,
    input  irq_ext_i, irq_sw_i, irq_tmr_i,
    input  mstatus_i, mie_i, mtvec_i, mepc_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o,
    output busy_o, stall_o, flush_o, jump_o, jump_addr_o
  );
endinterface

// File: rtl/trap_ctrl_prio.sv
// Priority encoder picking the trap/mret to take from the EX instruction and pending interrupts.
// Latency: combinational; Backpressure: none.
module trap_ctrl_prio
  import trap_ctrl_pkg::*;
(
  input  logic  ex_valid,
  input  logic  ecall,
  input  logic  ebreak,
  input  logic  mret,
  input  logic  irq_ext,
  input  logic  irq_sw,
  input  logic  irq_tmr,
  input  logic  mstatus_mie,
  input  logic  mie_meie,
  input  logic  mie_msie,
  input  logic  mie_mtie,
  output prio_t prio
);

  logic irq_en;

  assign irq_en = ex_valid & mstatus_mie;

  always_comb begin
    prio = '0;
    if (irq_en && irq_ext && mie_meie) begin
      prio.take   = 1'b1;
      prio.is_irq = 1'b1;
      prio.cause  = CAUSE_IRQ_EXT;
    end else if (irq_en && irq_sw && mie_msie) begin
      prio.take   = 1'b1;
      prio.is_irq = 1'b1;
      prio.cause  = CAUSE_IRQ_SW;
    end else if (irq_en && irq_tmr && mie_mtie) begin
      prio.take   = 1'b1;
      prio.is_irq = 1'b1;
      prio.cause  = CAUSE_IRQ_TMR;
    end else if (ex_valid && ecall) begin
      prio.take  = 1'b1;
      prio.cause = CAUSE_ECALL;
    end else if (ex_valid && ebreak) begin
      prio.take  = 1'b1;
      prio.cause = CAUSE_EBREAK;
    end else if (ex_valid && mret) begin
      prio.take    = 1'b1;
      prio.is_mret = 1'b1;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer walking the CSR write port; trap redirects at T+4, mret at T+2.
// Backpressure: none; stall_o holds the pipeline for the whole sequence and new events are ignored while busy_o.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  trap_ctrl_if.slave bus
);

  prio_t                 prio;
  state_e                state_q, state_d;
  logic                  accept;
  logic                  busy;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] cause_q;
  logic [DATA_WIDTH-1:0] mstatus_q;
  logic [DATA_WIDTH-1:0] mtvec_q;
  logic                  is_irq_q;
  logic                  is_mret_q;

  logic                      csr_we;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
  logic [DATA_WIDTH-1:0]     csr_wdata;
  logic                      flush;
  logic                      jump;
  logic [ADDR_WIDTH-1:0]     jump_addr;

  logic unused_mie;
  assign unused_mie = ^{bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:4], bus.mie_i[2:0]};

  trap_ctrl_prio u_prio (
    .ex_valid    (bus.ex_valid_i),
    .ecall       (bus.ecall_i),
    .ebreak      (bus.ebreak_i),
    .mret        (bus.mret_i),
    .irq_ext     (bus.irq_ext_i),
    .irq_sw      (bus.irq_sw_i),
    .irq_tmr     (bus.irq_tmr_i),
    .mstatus_mie (bus.mstatus_i[MSTATUS_MIE]),
    .mie_meie    (bus.mie_i[MIE_MEIE]),
    .mie_msie    (bus.mie_i[MIE_MSIE]),
    .mie_mtie    (bus.mie_i[MIE_MTIE]),
    .prio        (prio)
  );

  // Gating with rst_ni keeps stall_o low while reset is held, even with events present.
  assign accept = rst_ni & (state_q == ST_IDLE) & prio.take;
  assign busy   = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= '0;
      cause_q   <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
    end else if (accept) begin
      pc_q      <= bus.ex_pc_i;
      cause_q   <= prio.cause;
      mstatus_q <= bus.mstatus_i;
      mtvec_q   <= bus.mtvec_i;
      is_irq_q  <= prio.is_irq;
      is_mret_q <= prio.is_mret;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    csr_we    = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    flush     = 1'b0;
    jump      = 1'b0;
    jump_addr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = prio.is_mret ? ST_MRET_MSTATUS : ST_WR_MEPC;
        end
      end
      ST_WR_MEPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = pc_q;
        state_d   = ST_WR_MCAUSE;
      end
      ST_WR_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_q;
        state_d   = ST_WR_MSTATUS;
      end
      ST_WR_MSTATUS: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = trap_mstatus(mstatus_q);
        state_d   = ST_REDIRECT;
      end
      ST_MRET_MSTATUS: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mret_mstatus(mstatus_q);
        state_d   = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        // mret returns to the mepc the CSR file holds now, not a snapshot.
        flush     = 1'b1;
        jump      = 1'b1;
        jump_addr = is_mret_q ? bus.mepc_i : trap_target(mtvec_q, cause_q, is_irq_q);
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.csr_we_o    = csr_we;
  assign bus.csr_waddr_o = csr_waddr;
  assign bus.csr_wdata_o = csr_wdata;
  assign bus.busy_o      = busy;
  assign bus.stall_o     = busy | accept;
  assign bus.flush_o     = flush;
  assign bus.jump_o      = jump;
  assign bus.jump_addr_o = jump_addr;

endmodule
